// File: rtl/trisc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// trisc_mem_arbiter
//
// Shares the single-port TRISC program/data RAM between the CPU controller
// (fetch, LDA, STA and ADD operand reads) and the external program loader.
// One access is in flight at a time. Each access holds mem_en for MEM_LAT
// cycles, captures the RAM read data on the last of them, and then returns
// a one-cycle ack to whichever requester won. An anti-starvation counter
// hands the RAM to the loader after STARVE_MAX back-to-back CPU grants made
// while the loader was waiting.
//
// All registers update on the falling edge of SysClock. SysReset is
// synchronous and active high, and every output is registered.
//
// Ports
//   SysClock, SysReset        clock (falling-edge active) and sync reset
//   cpu_req/we/addr/wdata     CPU request; held stable until cpu_ack
//   cpu_ack, cpu_rdata        one-cycle completion pulse and read data
//   ldr_req/we/addr/wdata     loader request; held stable until ldr_ack
//   ldr_ack, ldr_rdata        one-cycle completion pulse and read data
//   mem_en, mem_we            RAM enable and write strobe
//   mem_addr, mem_wdata       RAM address and write data
//   mem_rdata                 RAM read data, valid at end of the last access cycle
//   ldr_owner                 high from the loader grant edge through its ack cycle
// ---------------------------------------------------------------------------
module trisc_mem_arbiter #(
  parameter int AW         = 4,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          SysClock,
  input  logic          SysReset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,

  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          ldr_owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [CW-1:0] lat_cnt;

  logic          ldr_wins;
  logic          cpu_wins;
  logic [SW-1:0] starve_next;

  // The CPU has priority, except when the loader has already watched
  // STARVE_MAX CPU grants go by; then the loader takes the next slot.
  // starve_next is the counter value after a CPU grant: it only counts
  // grants made while the loader is waiting, and it saturates.
  always_comb begin
    ldr_wins    = ldr_req && (!cpu_req || (starve_cnt == STARVE_LIM));
    cpu_wins    = cpu_req && !ldr_wins;
    starve_next = '0;
    if (ldr_req) begin
      if (starve_cnt == STARVE_LIM) begin
        starve_next = starve_cnt;
      end else begin
        starve_next = starve_cnt + SW'(1);
      end
    end
  end

  // Single control FSM. The RAM-side outputs double as the capture
  // registers for the winner's we/addr/wdata, so during ACCESS mem_we and
  // ldr_owner tell us what kind of access it is and whom to answer.
  // Acks default low each cycle and are raised only on the edge into RESP,
  // which makes them one-cycle pulses and keeps them mutually exclusive.
  always_ff @(negedge SysClock) begin
    if (SysReset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_ack    <= 1'b0;
      ldr_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ldr_owner  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (ldr_wins) begin
            state      <= ACCESS;
            ldr_owner  <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= ldr_we;
            mem_addr   <= ldr_addr;
            mem_wdata  <= ldr_wdata;
            lat_cnt    <= LAT_LOAD;
            starve_cnt <= '0;
          end else if (cpu_wins) begin
            state      <= ACCESS;
            ldr_owner  <= 1'b0;
            mem_en     <= 1'b1;
            mem_we     <= cpu_we;
            mem_addr   <= cpu_addr;
            mem_wdata  <= cpu_wdata;
            lat_cnt    <= LAT_LOAD;
            starve_cnt <= starve_next;
          end else begin
            // No request at all, so the loader is not waiting.
            starve_cnt <= '0;
          end
        end

        ACCESS: begin
          if (lat_cnt == '0) begin
            // Last enable cycle: the RAM data is valid now. Writes
            // answer with zero data.
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (ldr_owner) begin
              ldr_ack   <= 1'b1;
              ldr_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= mem_we ? '0 : mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end

        RESP: begin
          // Read data is only meaningful alongside the ack; clear it so
          // a stale value never lingers on the bus.
          state     <= IDLE;
          ldr_owner <= 1'b0;
          cpu_rdata <= '0;
          ldr_rdata <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trisc_mem_arbiter
//
// Bench for trisc_mem_arbiter. A small RAM model hangs off the memory port.
// A transaction-level reference model keeps its own copy of the memory, an
// arbitration decision per free slot and a starvation count; every grant it
// predicts pushes the expected ack (cycle, owner, data) into a scoreboard
// queue that the monitor pops when the DUT acks. The same model predicts
// the mem_en / mem_we / ldr_owner windows from the grant cycle.
// The DUT updates on falling edges; the bench drives just after a falling
// edge and samples on the rising edge.
// ---------------------------------------------------------------------------
module tb_trisc_mem_arbiter;

  localparam int AW         = 4;
  localparam int DW         = 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic          SysClock = 1'b0;
  logic          SysReset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req, ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          ldr_owner;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  trisc_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .SysClock (SysClock),
    .SysReset (SysReset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .ldr_req  (ldr_req),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_ack  (ldr_ack),
    .ldr_rdata(ldr_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .ldr_owner(ldr_owner)
  );

  always #5 SysClock = ~SysClock;

  always @(negedge SysClock) cyc <= cyc + 1;

  // RAM seen by the DUT: combinational read, write on the active edge.
  logic [DW-1:0] ram [16] = '{default: '0};
  assign mem_rdata = mem_en ? ram[mem_addr] : '0;
  always @(negedge SysClock) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int            cyc;
    bit            ldr;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         sb[$];
  logic [DW-1:0] refmem [16] = '{default: '0};
  bit            m_active;
  int            m_grant;
  bit            m_ldr, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            starve;

  initial begin : monitor_model
    int    ph;
    bit    e_en, e_own, g_ldr, g_any;
    resp_t r;
    m_active = 1'b0;
    starve   = 0;
    forever begin
      @(posedge SysClock);
      if (SysReset) begin
        m_active = 1'b0;
        starve   = 0;
        sb.delete();
      end else begin
        // Expected RAM-port window: enable for MEM_LAT cycles after the
        // grant, loader ownership through the ack cycle.
        ph    = m_active ? (cyc - m_grant) : 0;
        e_en  = m_active && ph >= 1 && ph <= MEM_LAT;
        e_own = m_active && m_ldr && ph >= 1;
        check_output("mem_en", 32'(mem_en), 32'(e_en));
        check_output("mem_we", 32'(mem_we), 32'(e_en && m_we));
        check_output("ldr_owner", 32'(ldr_owner), 32'(e_own));
        if (e_en) begin
          check_output("mem_addr", 32'(mem_addr), 32'(m_addr));
          if (m_we) check_output("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
        check_output("ack_overlap", 32'(cpu_ack && ldr_ack), 32'(0));

        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          flag_fail("ack_missing", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
        if (cpu_ack || ldr_ack) begin
          if (sb.size() == 0) begin
            flag_fail("ack_unexpected", 1, 0);
          end else begin
            r = sb.pop_front();
            check_output("ack_cycle", 32'(cyc), 32'(r.cyc));
            check_output("ack_owner", 32'(ldr_ack), 32'(r.ldr));
            check_output("rdata", 32'(r.ldr ? ldr_rdata : cpu_rdata), 32'(r.data));
          end
        end

        // Arbitration for the slot that ends at the next active edge.
        if (m_active) begin
          if (ph == MEM_LAT + 1) m_active = 1'b0;
        end else begin
          g_any = 1'b0;
          g_ldr = 1'b0;
          if (ldr_req && (!cpu_req || starve == STARVE_MAX)) begin
            g_any = 1'b1;
            g_ldr = 1'b1;
            starve = 0;
          end else if (cpu_req) begin
            g_any  = 1'b1;
            starve = ldr_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
          end else begin
            starve = 0;
          end
          if (g_any) begin
            m_active = 1'b1;
            m_grant  = cyc;
            m_ldr    = g_ldr;
            m_we     = g_ldr ? ldr_we    : cpu_we;
            m_addr   = g_ldr ? ldr_addr  : cpu_addr;
            m_wdata  = g_ldr ? ldr_wdata : cpu_wdata;
            r.cyc    = cyc + MEM_LAT + 1;
            r.ldr    = g_ldr;
            r.data   = m_we ? '0 : refmem[m_addr];
            if (m_we) refmem[m_addr] = m_wdata;
            sb.push_back(r);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge SysClock);
    #1;
  endtask

  task automatic apply_stimulus(input bit ldr, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic random_request(input bit ldr);
    apply_stimulus(ldr, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom()));
  endtask

  task automatic wait_ack(input bit ldr, output int at);
    int n;
    n = 0;
    while (!(ldr ? ldr_ack : cpu_ack) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) flag_fail(ldr ? "ldr_ack_timeout" : "cpu_ack_timeout", n, 40);
    at = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_mem_en"},    32'(mem_en),    32'(0));
    check_output({tag, "_mem_we"},    32'(mem_we),    32'(0));
    check_output({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
    check_output({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check_output({tag, "_cpu_ack"},   32'(cpu_ack),   32'(0));
    check_output({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(0));
    check_output({tag, "_ldr_ack"},   32'(ldr_ack),   32'(0));
    check_output({tag, "_ldr_rdata"}, 32'(ldr_rdata), 32'(0));
    check_output({tag, "_ldr_owner"}, 32'(ldr_owner), 32'(0));
  endtask

  // One random drive decision per requester: after an ack either keep the
  // request up with fresh qualifiers (back-to-back) or drop it.
  task automatic drive_random(input int cpu_rate, input int ldr_rate, input bit keep_ok);
    if (cpu_req) begin
      if (cpu_ack) begin
        if (keep_ok && $urandom_range(0, 1) == 1) random_request(1'b0);
        else cpu_req = 1'b0;
      end
    end else if (int'($urandom_range(1, 100)) <= cpu_rate) begin
      random_request(1'b0);
    end
    if (ldr_req) begin
      if (ldr_ack) begin
        if (keep_ok && $urandom_range(0, 1) == 1) random_request(1'b1);
        else ldr_req = 1'b0;
      end
    end else if (int'($urandom_range(1, 100)) <= ldr_rate) begin
      random_request(1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : stimulus
    int t1, t2, cnt, n, crate, lrate;
    SysReset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    SysReset = 1'b0;
    step();

    $display("[TB] loader write F <= 5C");
    apply_stimulus(1'b1, 1'b1, 4'hF, 8'h5C);
    wait_ack(1'b1, t1);
    check_output("ldr_write_rdata", 32'(ldr_rdata), 32'(0));
    check_output("ldr_write_owner", 32'(ldr_owner), 32'(1));
    check_output("ram_f", 32'(ram[15]), 32'h5C);
    ldr_req = 1'b0;

    $display("[TB] CPU read of address 3 holding A7");
    apply_stimulus(1'b1, 1'b1, 4'h3, 8'hA7);
    step();
    wait_ack(1'b1, t1);
    ldr_req = 1'b0;
    step();
    apply_stimulus(1'b0, 1'b0, 4'h3, 8'h00);
    wait_ack(1'b0, t1);
    check_output("cpu_rdata_a7", 32'(cpu_rdata), 32'hA7);
    cpu_req = 1'b0;
    step();

    $display("[TB] simultaneous requests");
    apply_stimulus(1'b0, 1'b0, 4'hF, 8'h00);
    apply_stimulus(1'b1, 1'b0, 4'h0, 8'h00);
    wait_ack(1'b0, t1);
    cpu_req = 1'b0;
    wait_ack(1'b1, t2);
    ldr_req = 1'b0;
    check_output("cpu_then_ldr_gap", 32'(t2 - t1), 32'(MEM_LAT + 2));
    step();

    $display("[TB] starvation limit");
    apply_stimulus(1'b0, 1'b0, AW'($urandom_range(0, 15)), 8'h00);
    apply_stimulus(1'b1, 1'b1, 4'h9, 8'h96);
    cnt = 0;
    n = 0;
    while (!ldr_ack && n < 80) begin
      step();
      n++;
      if (cpu_ack) begin
        cnt++;
        apply_stimulus(1'b0, 1'b0, AW'($urandom_range(0, 15)), 8'h00);
      end
    end
    if (n >= 80) flag_fail("starve_timeout", n, 80);
    check_output("starve_cpu_acks", 32'(cnt), 32'(STARVE_MAX));
    t1 = cyc;
    ldr_req = 1'b0;
    wait_ack(1'b0, t2);
    check_output("cpu_resumes", 32'(t2 - t1), 32'(MEM_LAT + 2));
    cpu_req = 1'b0;
    step();

    $display("[TB] held request restarts immediately");
    apply_stimulus(1'b0, 1'b0, 4'h9, 8'h00);
    wait_ack(1'b0, t1);
    step();
    wait_ack(1'b0, t2);
    check_output("back_to_back_gap", 32'(t2 - t1), 32'(MEM_LAT + 2));
    cpu_req = 1'b0;
    repeat (2) step();

    $display("[TB] reset during CPU write");
    apply_stimulus(1'b0, 1'b1, 4'h5, 8'h3C);
    step();
    check_output("rst_access1_en", 32'(mem_en), 32'(1));
    step();
    check_output("rst_access2_we", 32'(mem_we), 32'(1));
    SysReset = 1'b1;
    cpu_req  = 1'b0;
    step();
    SysReset = 1'b0;
    check_idle_outputs("after_reset");
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("no_ack_after_reset", 32'(cpu_ack), 32'(0));
    end

    $display("[TB] random traffic");
    for (int blk = 0; blk < 4; blk++) begin
      crate = (blk % 2 == 1) ? 100 : int'($urandom_range(20, 80));
      lrate = int'($urandom_range(20, 100));
      for (int i = 0; i < 200; i++) begin
        step();
        drive_random(crate, lrate, 1'b1);
      end
    end
    n = 0;
    while ((cpu_req || ldr_req) && n < 100) begin
      step();
      n++;
      drive_random(0, 0, 1'b0);
    end
    if (n >= 100) flag_fail("drain_timeout", n, 100);
    repeat (6) step();
    check_output("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
